// File: rtl/alu_ft_pkg.sv
// alu_ft_pkg: shared types and constants for the fault-tolerant ALU lane demux.
//   state_t   : demux FSM states (IDLE, HOLD_A, HOLD_B)
//   LANE_A/B  : lane encodings, same polarity as the downstream 2:1 result mux
//   DEF_*     : default WIDTH / TIMEOUT parameter values
//   pick_lane : effective lane choice from select and lane fail flags
package alu_ft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  localparam logic LANE_A = 1'b1;
  localparam logic LANE_B = 1'b0;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;

  // Returns {lane_exists, lane}. The selected lane wins when healthy,
  // otherwise the other lane is used if it is healthy.
  function automatic logic [1:0] pick_lane(input logic sel,
                                           input logic a_fail,
                                           input logic b_fail);
    logic [1:0] r;
    r = {1'b0, LANE_B};
    if (sel == LANE_A && !a_fail)      r = {1'b1, LANE_A};
    else if (sel == LANE_B && !b_fail) r = {1'b1, LANE_B};
    else if (!a_fail)                  r = {1'b1, LANE_A};
    else if (!b_fail)                  r = {1'b1, LANE_B};
    return r;
  endfunction

endpackage

// File: rtl/lane_timeout_ctr.sv
// lane_timeout_ctr: stall counter for a held word.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear counter (state change or handshake)
//   inc      : count one stalled cycle
//   expire   : count has reached TIMEOUT-1 (counter saturates there)
module lane_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/alu_lane_demux.sv
// alu_lane_demux: single-entry registered 1-to-2 demux feeding redundant ALU lanes.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_data: upstream operand handshake
//   s                        : lane select at accept (1 = lane A, 0 = lane B)
//   lane_a_fail, lane_b_fail : lane fault flags (level)
//   out_a_* / out_b_*        : per-lane valid/ready/data
//   err                      : both lanes failed (registered)
//   fault_stb                : one-cycle pulse on timeout failover
// Optional feature macro LANE_TIMEOUT_EN: a word stalled TIMEOUT cycles on a lane
// is moved to the other healthy lane. Without it fault_stb is tied low.
module alu_lane_demux
  import alu_ft_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s,
  input  logic             lane_a_fail,
  input  logic             lane_b_fail,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             err,
  output logic             fault_stb
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("alu_lane_demux: TIMEOUT must be >= 2");
  end

  state_t     state;
  logic [1:0] pick;
  logic       eff_ok;
  logic       eff_lane;
  logic       hs_a;
  logic       hs_b;
  logic       accept;
  logic       failover;

  assign pick     = pick_lane(s, lane_a_fail, lane_b_fail);
  assign eff_ok   = pick[1];
  assign eff_lane = pick[0];

  assign hs_a = (state == HOLD_A) && out_a_ready;
  assign hs_b = (state == HOLD_B) && out_b_ready;

  // The slot frees in the same cycle the held word is taken, so a new
  // word can be accepted back to back.
  assign in_ready = !rst && eff_ok && ((state == IDLE) || hs_a || hs_b);
  assign accept   = in_valid && in_ready;

  assign out_a_valid = (state == HOLD_A);
  assign out_b_valid = (state == HOLD_B);

`ifdef LANE_TIMEOUT_EN
  logic stall;
  logic expire;
  logic other_ok;

  assign stall    = ((state == HOLD_A) && !out_a_ready) ||
                    ((state == HOLD_B) && !out_b_ready);
  assign other_ok = (state == HOLD_A) ? !lane_b_fail : !lane_a_fail;
  // With the other lane failed the counter saturates and the word stays put.
  assign failover = stall && expire && other_ok;

  lane_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (failover || hs_a || hs_b),
    .inc    (stall),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) fault_stb <= 1'b0;
    else     fault_stb <= failover;
  end
`else
  assign failover  = 1'b0;
  assign fault_stb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_a_data <= '0;
      out_b_data <= '0;
      err        <= 1'b0;
    end else begin
      err <= lane_a_fail && lane_b_fail;
      if (accept) begin
        if (eff_lane == LANE_A) begin
          state      <= HOLD_A;
          out_a_data <= in_data;
        end else begin
          state      <= HOLD_B;
          out_b_data <= in_data;
        end
      end else if (hs_a || hs_b) begin
        state <= IDLE;
      end else if (failover) begin
        if (state == HOLD_A) begin
          state      <= HOLD_B;
          out_b_data <= out_a_data;
        end else begin
          state      <= HOLD_A;
          out_a_data <= out_b_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_lane_demux.sv
module tb_alu_lane_demux;

  localparam int W  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, s, fa, fb, ra, rb;
  logic [W-1:0] in_data;
  logic         in_ready, a_valid, b_valid, err, fault_stb;
  logic [W-1:0] a_data, b_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: one optional pending word, which lane it sits on,
  // the last data shown on each lane, and how long it has been stuck.
  bit           m_busy;
  bit           m_on_a;
  logic [W-1:0] m_a_data, m_b_data;
  bit           m_err, m_stb;
  int           m_stuck;

  always #5 clk = ~clk;

  alu_lane_demux #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .s           (s),
    .lane_a_fail (fa),
    .lane_b_fail (fb),
    .out_a_valid (a_valid),
    .out_a_ready (ra),
    .out_a_data  (a_data),
    .out_b_valid (b_valid),
    .out_b_ready (rb),
    .out_b_data  (b_data),
    .err         (err),
    .fault_stb   (fault_stb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which lane would a word go to right now: 1 = A, 0 = B, -1 = none.
  function automatic int target_lane();
    if (s && !fa) return 1;
    if (!s && !fb) return 0;
    if (!fa) return 1;
    if (!fb) return 0;
    return -1;
  endfunction

  function automatic bit model_ready();
    bit taken;
    taken = m_busy && (m_on_a ? ra : rb);
    return !rst && (target_lane() >= 0) && (!m_busy || taken);
  endfunction

  task automatic model_edge(input bit rdy);
    bit taken, acc;
    int tl;
    if (rst) begin
      m_busy = 0; m_a_data = '0; m_b_data = '0; m_err = 0; m_stb = 0; m_stuck = 0;
      return;
    end
    tl    = target_lane();
    taken = m_busy && (m_on_a ? ra : rb);
    acc   = in_valid && rdy;
    m_stb = 0;
`ifdef LANE_TIMEOUT_EN
    if (m_busy && !taken) begin
      if (m_stuck == TO - 1 && (m_on_a ? !fb : !fa)) begin
        if (m_on_a) m_b_data = m_a_data; else m_a_data = m_b_data;
        m_on_a  = !m_on_a;
        m_stb   = 1;
        m_stuck = 0;
      end else if (m_stuck < TO - 1) begin
        m_stuck++;
      end
    end
`endif
    if (taken) begin
      m_busy  = 0;
      m_stuck = 0;
    end
    if (acc) begin
      m_busy  = 1;
      m_on_a  = (tl == 1);
      m_stuck = 0;
      if (m_on_a) m_a_data = in_data; else m_b_data = in_data;
    end
    m_err = fa && fb;
  endtask

  task automatic step();
    bit rdy;
    #1;
    rdy = model_ready();
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    model_edge(rdy);
    #1;
    chk("a_valid", a_valid, m_busy && m_on_a);
    chk("b_valid", b_valid, m_busy && !m_on_a);
    chk("a_data", a_data, m_a_data);
    chk("b_data", b_data, m_b_data);
    chk("err", err, m_err);
    chk("fault_stb", fault_stb, m_stb);
    chk("exclusive", a_valid & b_valid, 0);
  endtask

  initial begin
    int a_run;
    m_busy = 0; m_on_a = 0; m_a_data = '0; m_b_data = '0;
    m_err = 0; m_stb = 0; m_stuck = 0;

    // Reset with a valid word waiting upstream
    rst = 1; in_valid = 1; in_data = 8'hEE; s = 1; fa = 0; fb = 0; ra = 1; rb = 1;
    step(); step();
    chk("rst_ready", in_ready, 0);
    chk("rst_a_data", a_data, 0);

    // Basic dispatch to A then B
    rst = 0; s = 1; in_data = 8'hA5; step();
    chk("t2_a_data", a_data, 8'hA5);
    chk("t2_a_valid", a_valid, 1);
    s = 0; in_data = 8'h3C; step();
    chk("t2_b_data", b_data, 8'h3C);
    in_valid = 0; step();

    // Back-pressure on lane B, then release with a simultaneous accept
    in_valid = 1; s = 0; in_data = 8'h11; rb = 0; step();
    in_data = 8'h99;
    for (int i = 0; i < 5; i++) step();
    chk("t3_hold", b_data, 8'h11);
    rb = 1; in_data = 8'h22; step();
    chk("t3_next", b_data, 8'h22);
    in_valid = 0; step();

    // Failed lane steering and both lanes failed
    fa = 1; in_valid = 1; s = 1; in_data = 8'h7E; step();
    chk("t4_route", b_data, 8'h7E);
    in_valid = 0; step();
    fb = 1; in_valid = 1; in_data = 8'h44; step();
    chk("t4_err", err, 1);
    step();
    fa = 0; fb = 0; in_valid = 0; step();

    // Stalled lane A
    in_valid = 1; s = 1; in_data = 8'h5A; ra = 0; rb = 0; step();
    in_valid = 0;
    a_run = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_valid) a_run++;
    end
`ifdef LANE_TIMEOUT_EN
    chk("t5_a_cycles", a_run, TO);
    chk("t5_b_data", b_data, 8'h5A);
`else
    chk("t5_a_stuck", a_run, 11);
`endif
    ra = 1; rb = 1; step();

    // Reset while holding on lane B
    in_valid = 1; s = 0; in_data = 8'hC3; rb = 0; step();
    in_valid = 0; rst = 1; step();
    chk("t6_b_valid", b_valid, 0);
    rst = 0; rb = 1; in_valid = 1; step();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_data  = W'($urandom);
      s        = $urandom_range(0, 1) != 0;
      fa       = ($urandom_range(0, 7) == 0);
      fb       = ($urandom_range(0, 7) == 0);
      ra       = $urandom_range(0, 2) != 0;
      rb       = $urandom_range(0, 2) != 0;
      if (i % 100 < 12) begin
        ra = 0; rb = 0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
